// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the multdiv issue sequencer.
// - state_e     : FSM encoding, 2 bits (IDLE/START/WAIT/DONE)
// - TIMEOUT_DEF : default WAIT cycle budget before a forced exception completion
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Signal bundle between execute stage / multdiv unit and the issue sequencer.
// Issue side : issue_valid, issue_is_div, issue_opA/B, issue_rd, flush -> stall, busy
// Writeback  : wb_valid, wb_rd, wb_data, wb_exception
// multdiv    : md_operandA/B, md_ctrl_MULT/DIV out; md_result, md_exception, md_resultRDY in
// Modports   : slave  = the sequencer, master = the environment driving it
interface multdiv_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);

  logic              issue_valid;
  logic              issue_is_div;
  logic [DATA_W-1:0] issue_opA;
  logic [DATA_W-1:0] issue_opB;
  logic [RD_W-1:0]   issue_rd;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;
  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;

  modport slave (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
           md_result, md_exception, md_resultRDY,
    output stall, busy, wb_valid, wb_rd, wb_data, wb_exception,
           md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );

  modport master (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
           md_result, md_exception, md_resultRDY,
    input  stall, busy, wb_valid, wb_rd, wb_data, wb_exception,
           md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );

endinterface

// File: rtl/multdiv_issue_ctrl_wait_counter.sv
// md_wait_counter: WAIT-cycle counter for the multdiv sequencer.
// - clock, reset : clock, synchronous active-high reset
// - clr_i        : load zero (wins over en_i)
// - en_i         : increment by one
// - cnt_o        : current count, $clog2(TIMEOUT) bits
// - tc_o         : terminal count, high while cnt_o == TIMEOUT-1
module md_wait_counter
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       en_i,
  output logic [$clog2(TIMEOUT)-1:0] cnt_o,
  output logic                       tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: sequencer between the execute stage and the shared multdiv.
// Accepts one mult/div, pulses md_ctrl_MULT/DIV for one cycle, stalls the
// front end until multdiv reports ready (or TIMEOUT WAIT cycles elapse), then
// presents a single-cycle writeback beat. Flush aborts START/WAIT silently.
// - clock, reset : clock, synchronous active-high reset
// - bus          : multdiv_issue_ctrl_if.slave (issue, writeback, multdiv signals)
module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_issue_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [RD_W-1:0]   rd_q;
  logic              div_q;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_exc_q, wb_exc_d;
  logic [RD_W-1:0]   wb_rd_q;
  logic              wb_valid_q;
  logic              accept;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]     cnt;

  md_wait_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign accept = (state_q == S_IDLE) && bus.issue_valid && !bus.flush;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_exc_d  = wb_exc_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        cnt_clr = 1'b1;
        state_d = bus.flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_en = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.md_resultRDY && (cnt != '0)) begin
          // cnt==0 is the first WAIT cycle; RDY there is the previous op's level
          wb_data_d = bus.md_result;
          wb_exc_d  = bus.md_exception;
          state_d   = S_DONE;
        end else if (cnt_tc) begin
          wb_data_d = '0;
          wb_exc_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      // already committed: flush here does not cancel the writeback
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch plus writeback registers; wb_valid/wb_rd are live only in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      div_q      <= 1'b0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        opa_q <= bus.issue_opA;
        opb_q <= bus.issue_opB;
        rd_q  <= bus.issue_rd;
        div_q <= bus.issue_is_div;
      end
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
      wb_valid_q <= (state_d == S_DONE);
      wb_rd_q    <= (state_d == S_DONE) ? rd_q : '0;
    end
  end

  // stall drops combinationally on flush so the squashed instruction frees X at once
  assign bus.stall        = accept ||
                            (((state_q == S_START) || (state_q == S_WAIT)) && !bus.flush);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.md_ctrl_MULT = (state_q == S_START) && !div_q;
  assign bus.md_ctrl_DIV  = (state_q == S_START) &&  div_q;
  assign bus.md_operandA  = opa_q;
  assign bus.md_operandB  = opb_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: directed scenarios then random ops.
// A behavioural multdiv answers each start pulse after a chosen latency and
// keeps RDY high afterwards; expected writebacks are queued at issue time and
// popped by an independent monitor.
module tb_multdiv_issue_ctrl;
  import multdiv_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multdiv_issue_ctrl_if #(.DATA_W(DW), .RD_W(RW)) bus ();

  multdiv_issue_ctrl #(.DATA_W(DW), .RD_W(RW), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          exc;
    int            dly;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0, npass = 0;
  int   cyc = 0, pulses = 0, pulse_cyc = 0;
  int   since = 100000, lat_cur = 100000, lat_cfg = 0;
  logic cur_div = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // multdiv behaviour: {exception, result}
  function automatic logic [DW:0] ref_md(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic div);
    logic [DW-1:0] p;
    if (!div) begin
      p = a * b;
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, {DW{1'b0}}};
    p = a / b;
    return {1'b0, p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 0);
    chk({tag, "_wb_rd"}, 64'(bus.wb_rd), 0);
    chk({tag, "_wb_data"}, 64'(bus.wb_data), 0);
    chk({tag, "_wb_exc"}, 64'(bus.wb_exception), 0);
    chk({tag, "_opA"}, 64'(bus.md_operandA), 0);
    chk({tag, "_opB"}, 64'(bus.md_operandB), 0);
    chk({tag, "_mult"}, 64'(bus.md_ctrl_MULT), 0);
    chk({tag, "_div"}, 64'(bus.md_ctrl_DIV), 0);
    chk({tag, "_stall"}, 64'(bus.stall), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
  endtask

  // One cycle: advance to negedge, then step the multdiv model.
  task automatic tick();
    logic [DW:0] r;
    @(negedge clock);
    if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
      chk("pulse_kind", {62'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, {62'd0, !cur_div, cur_div});
      pulses++;
      since     = 0;
      lat_cur   = lat_cfg;
      pulse_cyc = cyc;
      r = ref_md(bus.md_operandA, bus.md_operandB, bus.md_ctrl_DIV);
      bus.md_result    = r[DW-1:0];
      bus.md_exception = r[DW];
    end else if (since < 100000) begin
      since++;
    end
    // the previous RDY level persists through the pulse cycle and one more
    if (since >= 2) bus.md_resultRDY = (since >= lat_cur);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.issue_valid = 1'b0;
      bus.flush = 1'b0;
    end
  endtask

  // mode 0: normal, 1: flush at since==at, 2: reset at since==at, 3: flush during DONE
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic div,
                        input logic [RW-1:0] rd, input int lat, input int mode, input int at);
    int          p0, sc, trig, mn;
    bit          brk;
    exp_t        e;
    logic [DW:0] r;
    p0  = pulses;
    sc  = 0;
    brk = 0;
    mn  = (lat < TO) ? lat : TO;
    trig = (mode == 3) ? mn + 1 : at;
    tick();
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = div;
    bus.issue_opA    = a;
    bus.issue_opB    = b;
    bus.issue_rd     = rd;
    lat_cfg = lat;
    cur_div = div;
    if (mode == 0 || mode == 3) begin
      r = (lat <= TO) ? ref_md(a, b, div) : {1'b1, {DW{1'b0}}};
      e.rd = rd; e.data = r[DW-1:0]; e.exc = r[DW]; e.dly = mn + 1;
      sb.push_back(e);
    end
    for (int n = 0; n < 300 && !brk; n++) begin
      if (n > 0) tick();
      bus.flush = 1'b0;
      if (pulses == p0 + 1 && since == trig) begin
        if (mode == 1) begin bus.flush = 1'b1; bus.issue_valid = 1'b0; end
        else if (mode == 2) begin reset = 1'b1; bus.issue_valid = 1'b0; end
        else if (mode == 3) bus.flush = 1'b1;
      end
      #1;
      if (mode == 1 && bus.flush) begin
        chk("flush_stall", 64'(bus.stall), 0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_busy", 64'(bus.busy), 0);
        brk = 1;
      end else if (mode == 2 && reset) begin
        tick();
        reset = 1'b0;
        #1;
        chk_zero("rst_mid");
        brk = 1;
      end else if (!bus.stall) begin
        brk = 1;
      end else begin
        sc++;
      end
    end
    chk("op_end", 64'(brk), 1);
    chk("pulse_cnt", 64'(pulses - p0), 1);
    if (mode == 0 || mode == 3) chk("stall_cycles", 64'(sc), 64'(mn + 2));
  endtask

  // Monitor: every writeback beat must match the oldest queued expectation.
  initial begin
    exp_t e;
    logic prev_wb;
    prev_wb = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.wb_valid) begin
        chk("wb_single", 64'(prev_wb), 0);
        if (sb.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
          chk("wb_data", 64'(bus.wb_data), 64'(e.data));
          chk("wb_exc", 64'(bus.wb_exception), 64'(e.exc));
          chk("wb_delay", 64'(cyc - pulse_cyc), 64'(e.dly));
        end
      end
      prev_wb = bus.wb_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, nchk);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a, b;
    int lat, m, mode, at;
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_opA    = '0;
    bus.issue_opB    = '0;
    bus.issue_rd     = '0;
    bus.flush        = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk_zero("reset");

    run_op(32'd6,   32'd7, 1'b0, 5'd5, 17, 0, 0);   // multiply, 17-cycle latency
    run_op(32'd100, 32'd7, 1'b1, 5'd9, 10, 0, 0);   // divide with stale RDY
    run_op(32'd5,   32'd0, 1'b1, 5'd3, 6,  0, 0);   // divide by zero
    run_op(32'd8,   32'd8, 1'b0, 5'd4, 30, 1, 4);   // flush 4 cycles after pulse
    run_op(32'd3,   32'd3, 1'b0, 5'd6, 5,  0, 0);
    run_op(32'd9,   32'd9, 1'b0, 5'd7, 200, 0, 0);  // timeout
    run_op(32'd11,  32'd2, 1'b0, 5'd8, 64, 0, 0);   // RDY on the last WAIT cycle
    run_op(32'd12,  32'd2, 1'b0, 5'd10, 65, 0, 0);  // one cycle too late
    run_op(32'd2,   32'd3, 1'b0, 5'd1, 2,  0, 0);   // back-to-back, minimum latency
    run_op(32'd4,   32'd5, 1'b0, 5'd2, 3,  0, 0);
    run_op(32'd77,  32'd7, 1'b1, 5'd11, 8, 3, 0);   // flush in DONE still writes back
    run_op(32'd1,   32'd1, 1'b0, 5'd12, 40, 2, 5);  // reset in WAIT
    run_op(32'd3,   32'd3, 1'b0, 5'd13, 4,  0, 0);
    run_op(32'd50,  32'd5, 1'b1, 5'd14, 6,  1, 0);  // flush in START
    run_op(32'd50,  32'd5, 1'b1, 5'd15, 6,  0, 0);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      m   = $urandom_range(0, 3);
      b   = (m == 0) ? '0 : (m == 1) ? DW'($urandom_range(1, 1000)) : $urandom;
      lat = $urandom_range(2, 70);
      m   = $urandom_range(0, 7);
      mode = (m == 0) ? 1 : (m == 1) ? 3 : 0;
      at  = $urandom_range(0, (lat < TO) ? lat : TO);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      run_op(a, b, 1'($urandom_range(0, 1)), RW'($urandom), lat, mode, at);
    end

    idle(5);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
